// File: rtl/set_requester.sv
// Host-side request controller for the K-way CLOCK set.
// Issues set strobes, waits for completion or timeout, keeps hit/miss statistics.
module set_requester #(
    parameter int ADDR_WIDTH  = 8,
    parameter int LINE_WIDTH  = 32,
    parameter int K           = 2,
    parameter int MAX_WAIT    = 2 * K + 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [LINE_WIDTH-1:0]  req_wdata,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic                   resp_hit,
    output logic                   resp_err,
    output logic [LINE_WIDTH-1:0]  resp_rdata,
    output logic                   set_enable,
    output logic                   set_read,
    output logic                   set_write,
    output logic [ADDR_WIDTH-1:0]  set_addr,
    output logic [LINE_WIDTH-1:0]  set_wdata,
    input  logic                   set_hit,
    input  logic [LINE_WIDTH-1:0]  set_rdata,
    output logic [COUNT_WIDTH-1:0] stat_hits,
    output logic [COUNT_WIDTH-1:0] stat_misses
);

    localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] W_LAST = WW'(MAX_WAIT - 1);
    localparam logic [COUNT_WIDTH-1:0] C_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] C_ONE = COUNT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_WR_ISSUE,
        S_WR_WAIT,
        S_RESP
    } state_t;

    state_t                 r_state;
    logic [WW-1:0]          r_wait;
    logic                   r_set_enable;
    logic                   r_set_read;
    logic                   r_set_write;
    logic [ADDR_WIDTH-1:0]  r_set_addr;
    logic [LINE_WIDTH-1:0]  r_set_wdata;
    logic                   r_resp_valid;
    logic                   r_resp_hit;
    logic                   r_resp_err;
    logic [LINE_WIDTH-1:0]  r_resp_rdata;
    logic [COUNT_WIDTH-1:0] r_hits;
    logic [COUNT_WIDTH-1:0] r_misses;

    logic                   w_hits_sat;
    logic                   w_misses_sat;

    assign w_hits_sat   = (r_hits == C_MAX);
    assign w_misses_sat = (r_misses == C_MAX);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_wait       <= '0;
            r_set_enable <= 1'b0;
            r_set_read   <= 1'b0;
            r_set_write  <= 1'b0;
            r_set_addr   <= '0;
            r_set_wdata  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_hits       <= '0;
            r_misses     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_set_addr   <= req_addr;
                        r_set_wdata  <= req_wdata;
                        r_set_enable <= 1'b1;
                        r_set_read   <= !req_write;
                        r_set_write  <= req_write;
                        r_wait       <= '0;
                        r_state      <= req_write ? S_WR_ISSUE : S_RD_ISSUE;
                    end
                end
                S_RD_ISSUE: begin
                    r_set_enable <= 1'b0;
                    r_set_read   <= 1'b0;
                    r_state      <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    r_resp_valid <= 1'b1;
                    r_resp_hit   <= set_hit;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= set_hit ? set_rdata : '0;
                    if (set_hit && !w_hits_sat)
                        r_hits <= r_hits + C_ONE;
                    if (!set_hit && !w_misses_sat)
                        r_misses <= r_misses + C_ONE;
                    r_state <= S_RESP;
                end
                // set_hit here still reflects the previous operation
                S_WR_ISSUE: begin
                    r_state <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (set_hit) begin
                        r_set_enable <= 1'b0;
                        r_set_write  <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_hit   <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= '0;
                        if (!w_hits_sat)
                            r_hits <= r_hits + C_ONE;
                        r_state <= S_RESP;
                    end else if (r_wait == W_LAST) begin
                        r_set_enable <= 1'b0;
                        r_set_write  <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_hit   <= 1'b0;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= '0;
                        if (!w_misses_sat)
                            r_misses <= r_misses + C_ONE;
                        r_state <= S_RESP;
                    end else begin
                        r_wait <= r_wait + WW'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_set_enable <= 1'b0;
                    r_set_read   <= 1'b0;
                    r_set_write  <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign resp_valid  = r_resp_valid;
    assign resp_hit    = r_resp_hit;
    assign resp_err    = r_resp_err;
    assign resp_rdata  = r_resp_rdata;
    assign set_enable  = r_set_enable;
    assign set_read    = r_set_read;
    assign set_write   = r_set_write;
    assign set_addr    = r_set_addr;
    assign set_wdata   = r_set_wdata;
    assign stat_hits   = r_hits;
    assign stat_misses = r_misses;

endmodule

// File: tb/tb_set_requester.sv
// Randomized bench for set_requester with a cycle-level set stand-in
// and a transaction-level cache/latency reference.
module tb_set_requester;

    localparam int K  = 2;
    localparam int MW = 2 * K + 2;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_hit;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        set_enable;
    logic        set_read;
    logic        set_write;
    logic [7:0]  set_addr;
    logic [31:0] set_wdata;
    logic        set_hit;
    logic [31:0] set_rdata;
    logic [15:0] stat_hits;
    logic [15:0] stat_misses;

    logic        q_valid;
    logic        q_ready_o;
    logic        q_rvalid;
    logic        q_rready;
    logic        q_rhit;
    logic        q_rerr;
    logic [31:0] q_rdata;
    logic        q_en;
    logic        q_rd;
    logic        q_wr;
    logic [7:0]  q_addr;
    logic [31:0] q_wdata;
    logic        q_hit;
    logic [31:0] q_srdata;
    logic [1:0]  q_hits;
    logic [1:0]  q_misses;

    int n_cmp = 0;
    int n_bad = 0;

    set_requester #(.ADDR_WIDTH(8), .LINE_WIDTH(32), .K(K)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_hit(resp_hit), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .set_enable(set_enable), .set_read(set_read), .set_write(set_write),
        .set_addr(set_addr), .set_wdata(set_wdata),
        .set_hit(set_hit), .set_rdata(set_rdata),
        .stat_hits(stat_hits), .stat_misses(stat_misses)
    );

    set_requester #(.ADDR_WIDTH(8), .LINE_WIDTH(32), .K(K), .COUNT_WIDTH(2)) u_sat (
        .clock(clock), .reset_n(reset_n),
        .req_valid(q_valid), .req_ready(q_ready_o),
        .req_write(1'b0), .req_addr(8'h40), .req_wdata(32'h0),
        .resp_valid(q_rvalid), .resp_ready(q_rready),
        .resp_hit(q_rhit), .resp_err(q_rerr), .resp_rdata(q_rdata),
        .set_enable(q_en), .set_read(q_rd), .set_write(q_wr),
        .set_addr(q_addr), .set_wdata(q_wdata),
        .set_hit(q_hit), .set_rdata(q_srdata),
        .stat_hits(q_hits), .stat_misses(q_misses)
    );

    assign q_hit    = 1'b0;
    assign q_srdata = 32'h0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // cycle-level stand-in for the CLOCK-replacement set
    logic        env_clr;
    logic        stub_off;
    logic        s_valid [K];
    logic [7:0]  s_tag   [K];
    logic [31:0] s_data  [K];
    logic        s_ref   [K];
    logic        s_ptr;
    logic        s_pend;
    logic        s_hit;
    logic [31:0] s_rd;
    logic        s_found;
    logic        s_idx;

    always_comb begin
        s_found = 1'b0;
        s_idx   = 1'b0;
        for (int i = 0; i < K; i++) begin
            if (s_valid[i] && s_tag[i] == set_addr) begin
                s_found = 1'b1;
                s_idx   = 1'(i);
            end
        end
    end

    always @(posedge clock) begin
        if (env_clr) begin
            for (int i = 0; i < K; i++) begin
                s_valid[i] <= 1'b0;
                s_ref[i]   <= 1'b0;
            end
            s_ptr  <= 1'b0;
            s_pend <= 1'b0;
            s_hit  <= 1'b0;
            s_rd   <= '0;
        end else if (set_enable && !stub_off) begin
            if (set_read) begin
                s_hit <= s_found;
                s_rd  <= s_found ? s_data[s_idx] : 32'h0;
                if (s_found) s_ref[s_idx] <= 1'b1;
            end else if (set_write) begin
                s_rd <= '0;
                if (s_found) begin
                    s_data[s_idx] <= set_wdata;
                    s_ref[s_idx]  <= 1'b1;
                    s_hit         <= 1'b1;
                    s_pend        <= 1'b0;
                end else if (!s_pend) begin
                    s_pend <= 1'b1;
                    s_hit  <= 1'b0;
                end else if (!s_valid[s_ptr] || !s_ref[s_ptr]) begin
                    s_valid[s_ptr] <= 1'b1;
                    s_tag[s_ptr]   <= set_addr;
                    s_data[s_ptr]  <= set_wdata;
                    s_ref[s_ptr]   <= 1'b1;
                    s_ptr          <= ~s_ptr;
                    s_hit          <= 1'b1;
                    s_pend         <= 1'b0;
                end else begin
                    s_ref[s_ptr] <= 1'b0;
                    s_ptr        <= ~s_ptr;
                    s_hit        <= 1'b0;
                end
            end
        end else begin
            s_hit  <= 1'b0;
            s_pend <= 1'b0;
        end
    end

    assign set_hit   = stub_off ? 1'b0 : s_hit;
    assign set_rdata = s_rd;

    // transaction-level reference: cache contents, expected latency, stats
    logic        m_valid [K];
    logic [7:0]  m_tag   [K];
    logic [31:0] m_data  [K];
    logic        m_ref   [K];
    int          m_ptr;
    int          m_hits;
    int          m_misses;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < K; i++) begin
            m_valid[i] = 1'b0;
            m_ref[i]   = 1'b0;
        end
        m_ptr = 0;
    endtask

    task automatic model(input logic wr, input logic [7:0] a, input logic [31:0] d,
                         output logic hit, output logic [31:0] rd, output int lat);
        int f;
        int steps;
        f     = -1;
        steps = 0;
        rd    = 32'h0;
        lat   = 2;
        for (int i = 0; i < K; i++)
            if (m_valid[i] && m_tag[i] == a) f = i;
        if (!wr) begin
            hit = (f >= 0);
            if (hit) begin
                rd       = m_data[f];
                m_ref[f] = 1'b1;
            end
        end else begin
            hit = 1'b1;
            if (f >= 0) begin
                m_data[f] = d;
                m_ref[f]  = 1'b1;
            end else begin
                for (int n = 0; n < 2 * K + 1; n++) begin
                    steps++;
                    if (!m_valid[m_ptr] || !m_ref[m_ptr]) begin
                        m_valid[m_ptr] = 1'b1;
                        m_tag[m_ptr]   = a;
                        m_data[m_ptr]  = d;
                        m_ref[m_ptr]   = 1'b1;
                        m_ptr          = (m_ptr + 1) % K;
                        break;
                    end
                    m_ref[m_ptr] = 1'b0;
                    m_ptr        = (m_ptr + 1) % K;
                end
                lat = 2 + steps;
            end
        end
        if (hit) m_hits++;
        else m_misses++;
    endtask

    // one full host transaction; starts and ends #1 after a clock edge
    task automatic txn(input logic wr, input logic [7:0] a, input logic [31:0] d,
                       input int hold, input logic to, output int lat);
        logic        eh;
        logic        ee;
        logic [31:0] er;
        int          el;
        bit          got;
        ee = 1'b0;
        if (to) begin
            eh = 1'b0;
            ee = 1'b1;
            er = 32'h0;
            el = MW + 1;
            m_misses++;
        end else begin
            model(wr, a, d, eh, er, el);
        end
        stub_off  = to;
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(posedge clock);
            #1;
            lat++;
            got = resp_valid;
        end
        chk("resp_arrived", got, 1);
        if (got) begin
            chk("latency", lat, el);
            chk("resp_hit", resp_hit, eh);
            chk("resp_err", resp_err, ee);
            chk("resp_rdata", resp_rdata, er);
            chk("stat_hits", stat_hits, m_hits);
            chk("stat_misses", stat_misses, m_misses);
            chk("strobe_dropped", set_enable, 0);
            for (int h = 0; h < hold; h++) begin
                @(posedge clock);
                #1;
                chk("hold_valid", resp_valid, 1);
                chk("hold_rdata", resp_rdata, er);
                chk("hold_hit", resp_hit, eh);
                chk("hold_ready", req_ready, 0);
            end
            resp_ready = 1'b1;
            @(posedge clock);
            #1;
            resp_ready = 1'b0;
            chk("resp_cleared", resp_valid, 0);
            chk("ready_back", req_ready, 1);
        end
        stub_off = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic        eh;
        logic [31:0] er;
        int          el;
        bit          got;
        logic        wr;
        logic [7:0]  a;
        reset_n    = 1'b0;
        env_clr    = 1'b1;
        stub_off   = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        q_valid    = 1'b0;
        q_rready   = 1'b0;
        m_hits     = 0;
        m_misses   = 0;
        model_clear();

        repeat (3) @(posedge clock);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_set_enable", set_enable, 0);
        chk("rst_set_write", set_write, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_stat_hits", stat_hits, 0);
        chk("rst_stat_misses", stat_misses, 0);
        @(negedge clock);
        reset_n = 1'b1;
        env_clr = 1'b0;
        @(posedge clock);
        #1;

        txn(1'b0, 8'h10, 32'h0, 0, 1'b0, lat);
        chk("first_read_lat", lat, 2);
        chk("first_read_misses", stat_misses, 1);
        txn(1'b1, 8'h10, 32'hDEADBEEF, 0, 1'b0, lat);
        chk("first_write_lat", lat, 3);
        txn(1'b0, 8'h10, 32'h0, 0, 1'b0, lat);
        chk("readback_data", resp_rdata, 32'hDEADBEEF);
        chk("readback_hits", stat_hits, 2);

        env_clr = 1'b1;
        @(posedge clock);
        #1;
        env_clr = 1'b0;
        model_clear();
        txn(1'b1, 8'h01, 32'h1111, 0, 1'b0, lat);
        txn(1'b1, 8'h02, 32'h2222, 0, 1'b0, lat);
        txn(1'b1, 8'h01, 32'h1112, 0, 1'b0, lat);
        txn(1'b1, 8'h03, 32'h3333, 0, 1'b0, lat);
        chk("sweep_lat", lat, 5);
        txn(1'b0, 8'h01, 32'h0, 0, 1'b0, lat);
        chk("evicted_miss", resp_hit, 0);
        txn(1'b0, 8'h02, 32'h0, 4, 1'b0, lat);
        chk("kept_hit", resp_hit, 1);

        txn(1'b1, 8'h05, 32'h5555, 2, 1'b1, lat);
        chk("timeout_lat", lat, MW + 1);
        chk("timeout_wr_low", set_write, 0);

        // reset while the write strobe is held in the wait state
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'h02;
        req_wdata = 32'hCAFE0002;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("pre_rst_write", set_write, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_enable", set_enable, 0);
        chk("mid_rst_write", set_write, 0);
        chk("mid_rst_read", set_read, 0);
        chk("mid_rst_resp", resp_valid, 0);
        chk("mid_rst_ready", req_ready, 1);
        chk("mid_rst_hits", stat_hits, 0);
        model(1'b1, 8'h02, 32'hCAFE0002, eh, er, el);
        m_hits   = 0;
        m_misses = 0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        txn(1'b0, 8'h02, 32'h0, 0, 1'b0, lat);
        chk("post_rst_data", resp_rdata, 32'hCAFE0002);

        for (int t = 0; t < 80; t++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 8'h20 + 8'($urandom_range(0, 4));
            txn(wr, a, $urandom, $urandom_range(0, 3),
                wr && ($urandom_range(0, 15) == 0), lat);
        end

        for (int i = 0; i < 5; i++) begin
            q_valid = 1'b1;
            @(posedge clock);
            #1;
            q_valid = 1'b0;
            got = 1'b0;
            for (int n = 0; n < 20 && !got; n++) begin
                @(posedge clock);
                #1;
                got = q_rvalid;
            end
            chk("sat_arrived", got, 1);
            chk("sat_hit", q_rhit, 0);
            chk("sat_misses", q_misses, (i < 3) ? i + 1 : 3);
            q_rready = 1'b1;
            @(posedge clock);
            #1;
            q_rready = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
